// File: rtl/uart_defs.sv
// Shared types and constants for the UART bus bridge.
// Holds the bridge FSM encoding, command bytes and AXI beat constants.
package uart_defs;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    AW_W,
    B,
    AR,
    R,
    RESP
  } BridgeState_t;

  localparam logic [7:0] CMD_WRITE  = 8'h57;
  localparam logic [7:0] CMD_READ   = 8'h52;

  localparam logic [7:0] AXI_LEN1   = 8'd0;
  localparam logic [2:0] AXI_SIZE4  = 3'd2;
  localparam logic [1:0] AXI_INCR   = 2'b01;
  localparam logic [3:0] AXI_ID0    = 4'd0;
  localparam logic [3:0] AXI_STRB   = 4'hF;

  function automatic logic [31:0] shift_in(
    input logic [31:0] r,
    input logic [7:0]  b
  );
    return {r[23:0], b};
  endfunction

endpackage

// File: rtl/axi4.sv
// Single-beat AXI4 bundle between bridge (master) and bus (slave).
// 32-bit address/data, 4-bit ids; only the fields the bridge uses.
interface axi4;

  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [3:0]  awid;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arid;
  logic        arvalid;
  logic        arready;

  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awid, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arsize, arburst, arid, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awid, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arid, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

endinterface

// File: rtl/uart_bridge_rsp.sv
// Response serializer: loads a 1-byte (write) or 5-byte (read) reply.
// Ports: load/is_read/code/rdata in; out_data/out_valid/out_ready; done.
module uart_bridge_rsp
  import uart_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        is_read,
  input  logic [1:0]  code,
  input  logic [31:0] rdata,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        done
);

  logic [39:0] sh_q, sh_d;
  logic [2:0]  left_q, left_d;
  logic        fire;

  assign out_data  = sh_q[39:32];
  assign out_valid = (left_q != 3'd0);
  assign fire      = out_valid & out_ready;
  assign done      = fire & (left_q == 3'd1);

  always_comb begin
    sh_d   = sh_q;
    left_d = left_q;
    if (load) begin
      sh_d   = {6'b0, code, is_read ? rdata : 32'h0};
      left_d = is_read ? 3'd5 : 3'd1;
    end else if (fire) begin
      // Shifting zeros in keeps out_data at 0 once drained.
      sh_d   = {sh_q[31:0], 8'h00};
      left_d = left_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= '0;
      left_q <= '0;
    end else begin
      sh_q   <= sh_d;
      left_q <= left_d;
    end
  end

endmodule

// File: rtl/uart_bridge_master.sv
// UART command decoder issuing single-beat AXI4 reads/writes.
// Ports: in_* byte stream, out_* reply stream, bus (axi4.master), busy, timeout.
module uart_bridge_master
  import uart_defs::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  axi4.master        bus,
  output logic       busy,
  output logic       timeout
);

  localparam int TW =
    (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  BridgeState_t  state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          is_wr_q, is_wr_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [TW-1:0] to_q, to_d;
  logic          awv_q, awv_d;
  logic          wv_q, wv_d;
  logic          arv_q, arv_d;
  logic          tmo_q, tmo_d;

  logic          in_phase;
  logic          frame_phase;
  logic          expire;
  logic          in_fire;
  logic          rsp_load;
  logic          rsp_rd;
  logic [1:0]    rsp_code;
  logic          rsp_done;

  assign frame_phase = (state_q == ADDR) || (state_q == WDATA);
  assign in_phase    = (state_q == IDLE) || frame_phase;
  // Expiry wins over a byte arriving in the same cycle.
  assign expire      = TO_EN && frame_phase && (to_q == TO_MAX);
  assign in_ready    = in_phase & ~expire & ~rst;
  assign in_fire     = in_valid & in_ready;

  assign busy    = (state_q != IDLE);
  assign timeout = tmo_q;

  assign bus.awaddr  = addr_q;
  assign bus.awlen   = AXI_LEN1;
  assign bus.awsize  = AXI_SIZE4;
  assign bus.awburst = AXI_INCR;
  assign bus.awid    = AXI_ID0;
  assign bus.awvalid = awv_q;
  assign bus.wdata   = wdata_q;
  assign bus.wstrb   = AXI_STRB;
  assign bus.wlast   = 1'b1;
  assign bus.wvalid  = wv_q;
  assign bus.bready  = (state_q == B);
  assign bus.araddr  = addr_q;
  assign bus.arlen   = AXI_LEN1;
  assign bus.arsize  = AXI_SIZE4;
  assign bus.arburst = AXI_INCR;
  assign bus.arid    = AXI_ID0;
  assign bus.arvalid = arv_q;
  assign bus.rready  = (state_q == R);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_wr_d  = is_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    awv_d    = awv_q;
    wv_d     = wv_q;
    arv_d    = arv_q;
    tmo_d    = 1'b0;
    rsp_load = 1'b0;
    rsp_rd   = 1'b0;
    rsp_code = 2'b00;

    if (frame_phase && !in_fire && TO_EN)
      to_d = to_q + 1'b1;
    else
      to_d = '0;

    unique case (state_q)
      IDLE: begin
        cnt_d = 2'd0;
        if (in_fire) begin
          if (in_data == CMD_WRITE) begin
            is_wr_d = 1'b1;
            state_d = ADDR;
          end else if (in_data == CMD_READ) begin
            is_wr_d = 1'b0;
            state_d = ADDR;
          end
        end
      end
      ADDR: begin
        if (expire) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end else if (in_fire) begin
          addr_d = shift_in(addr_q, in_data);
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (is_wr_q) begin
              state_d = WDATA;
            end else begin
              state_d = AR;
              arv_d   = 1'b1;
            end
          end
        end
      end
      WDATA: begin
        if (expire) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end else if (in_fire) begin
          wdata_d = shift_in(wdata_q, in_data);
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = AW_W;
            awv_d   = 1'b1;
            wv_d    = 1'b1;
          end
        end
      end
      AW_W: begin
        if (bus.awready) awv_d = 1'b0;
        if (bus.wready)  wv_d  = 1'b0;
        if (!awv_d && !wv_d) state_d = B;
      end
      B: begin
        if (bus.bvalid) begin
          rsp_load = 1'b1;
          rsp_code = bus.bresp;
          state_d  = RESP;
        end
      end
      AR: begin
        if (bus.arready) begin
          arv_d   = 1'b0;
          state_d = R;
        end
      end
      R: begin
        if (bus.rvalid) begin
          rsp_load = 1'b1;
          rsp_rd   = 1'b1;
          rsp_code = bus.rresp;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (rsp_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      to_q    <= '0;
      awv_q   <= 1'b0;
      wv_q    <= 1'b0;
      arv_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      to_q    <= to_d;
      awv_q   <= awv_d;
      wv_q    <= wv_d;
      arv_q   <= arv_d;
      tmo_q   <= tmo_d;
    end
  end

  uart_bridge_rsp u_rsp (
    .clk      (clk),
    .rst      (rst),
    .load     (rsp_load),
    .is_read  (rsp_rd),
    .code     (rsp_code),
    .rdata    (bus.rdata),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .done     (rsp_done)
  );

endmodule

// File: tb/tb_uart_bridge_master.sv
// Directed bench for uart_bridge_master with a hand-driven AXI slave.
// Table of transactions plus timeout, garbage and reset sequences.
module tb_uart_bridge_master;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       timeout;

  axi4 bus_if ();

  always #5 clk = ~clk;

  uart_bridge_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .bus      (bus_if),
    .busy     (busy),
    .timeout  (timeout)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
    int          aw_dly;
    int          w_dly;
    int          stall_at;
    logic [39:0] exp;
    int          nb;
  } vec_t;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w;
    in_data  = b;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("in_ready_wait", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] v);
    for (int i = 3; i >= 0; i--) send_byte(v[i*8 +: 8]);
  endtask

  task automatic do_write(input vec_t v, input bit skip_b);
    int mx;
    send_byte(8'h57);
    send_word(v.addr);
    send_word(v.data);
    chk("awvalid_rise", bus_if.awvalid, 1);
    chk("wvalid_rise", bus_if.wvalid, 1);
    chk("awaddr", bus_if.awaddr, v.addr);
    chk("wdata", bus_if.wdata, v.data);
    chk("aw_attr", {bus_if.awlen, bus_if.awsize, bus_if.awburst},
        {8'd0, 3'd2, 2'b01});
    chk("wstrb", bus_if.wstrb, 4'hF);
    mx = (v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly;
    for (int k = 0; k <= mx; k++) begin
      chk("awvalid_hold", bus_if.awvalid, k <= v.aw_dly);
      chk("wvalid_hold", bus_if.wvalid, k <= v.w_dly);
      bus_if.awready = (k == v.aw_dly);
      bus_if.wready  = (k == v.w_dly);
      @(negedge clk);
    end
    bus_if.awready = 1'b0;
    bus_if.wready  = 1'b0;
    chk("awvalid_drop", bus_if.awvalid, 0);
    chk("wvalid_drop", bus_if.wvalid, 0);
    chk("bready", bus_if.bready, 1);
    if (!skip_b) begin
      bus_if.bvalid = 1'b1;
      bus_if.bresp  = v.resp;
      @(negedge clk);
      bus_if.bvalid = 1'b0;
      chk("wr_out_valid", out_valid, 1);
    end
  endtask

  task automatic do_read(input vec_t v);
    send_byte(8'h52);
    send_word(v.addr);
    chk("arvalid_rise", bus_if.arvalid, 1);
    chk("araddr", bus_if.araddr, v.addr);
    bus_if.arready = 1'b1;
    @(negedge clk);
    bus_if.arready = 1'b0;
    chk("arvalid_drop", bus_if.arvalid, 0);
    chk("rready", bus_if.rready, 1);
    bus_if.rvalid = 1'b1;
    bus_if.rdata  = v.data;
    bus_if.rresp  = v.resp;
    @(negedge clk);
    bus_if.rvalid = 1'b0;
    chk("rd_out_valid", out_valid, 1);
  endtask

  task automatic collect(input vec_t v);
    logic [7:0] eb;
    out_ready = 1'b1;
    for (int i = 0; i < v.nb; i++) begin
      eb = v.exp[39 - 8*i -: 8];
      if (i == v.stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, eb);
        end
        out_ready = 1'b1;
      end
      chk("rsp_valid", out_valid, 1);
      chk("rsp_byte", out_data, eb);
      @(negedge clk);
    end
    chk("rsp_end_valid", out_valid, 0);
    chk("rsp_end_busy", busy, 0);
    chk("rsp_end_in_ready", in_ready, 1);
  endtask

  task automatic run_vec(input vec_t v);
    if (v.wr) do_write(v, 1'b0);
    else      do_read(v);
    collect(v);
  endtask

  vec_t tv[6];
  bit   seen;

  initial begin
    tv[0] = '{1, 32'h4000_0010, 32'hDEAD_BEEF, 2'd0, 0, 0, -1,
              40'h00_0000_0000, 1};
    tv[1] = '{0, 32'h4000_0004, 32'h1234_5678, 2'd0, 0, 0, -1,
              40'h00_1234_5678, 5};
    tv[2] = '{1, 32'h4000_0020, 32'h0000_0001, 2'd2, 0, 3, -1,
              40'h02_0000_0000, 1};
    tv[3] = '{1, 32'h4000_0024, 32'h8000_0000, 2'd2, 3, 0, -1,
              40'h02_0000_0000, 1};
    tv[4] = '{0, 32'hFFFF_FFFC, 32'hCAFE_F00D, 2'd3, 0, 0, -1,
              40'h03_CAFE_F00D, 5};
    tv[5] = '{0, 32'h0000_0100, 32'hA5A5_0F0F, 2'd0, 0, 0, 2,
              40'h00_A5A5_0F0F, 5};

    rst = 1'b1;
    in_data = 8'h00;
    in_valid = 1'b0;
    out_ready = 1'b1;
    bus_if.awready = 1'b0;
    bus_if.wready  = 1'b0;
    bus_if.bvalid  = 1'b0;
    bus_if.bresp   = 2'd0;
    bus_if.arready = 1'b0;
    bus_if.rvalid  = 1'b0;
    bus_if.rdata   = 32'h0;
    bus_if.rresp   = 2'd0;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_valids", {bus_if.awvalid, bus_if.wvalid, bus_if.arvalid}, 0);
    chk("rst_readies", {bus_if.bready, bus_if.rready}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    for (int i = 0; i < 6; i++) run_vec(tv[i]);

    // Garbage byte is swallowed in IDLE.
    send_byte(8'hAA);
    chk("garbage_busy", busy, 0);

    // Partial read frame then a long gap.
    send_byte(8'h52);
    send_byte(8'h40);
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (bus_if.arvalid) seen = 1'b1;
      chk("tmo_pulse", timeout, i == 17);
      if (i == 15) chk("tmo_ready_before", in_ready, 1);
      if (i == 16) chk("tmo_ready_expiry", in_ready, 0);
      if (i == 17) chk("tmo_busy", busy, 0);
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk("tmo_no_ar_no_rsp", seen, 0);
    run_vec(tv[1]);

    // Reset while waiting for B.
    do_write(tv[0], 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstB_bready", bus_if.bready, 0);
    chk("rstB_busy", busy, 0);
    chk("rstB_valids", {bus_if.awvalid, bus_if.wvalid}, 0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("rstB_no_rsp", seen, 0);
    chk("rstB_in_ready", in_ready, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
